battle_sequencer: RTL and testbench

Parametrised turn sequencer for the battle screen: menu, action selection, attack resolution and a timed dodge phase, driven by the encoded keyboard and by the player, attack-bar and bullet blocks. Successor to the fixed single-monster game machine. Adds asynchronous reset, multiple monsters with per-monster HP and targeting, a tick-timed dodge phase and edge-detected menu keys. Its outputs are one-cycle instruction pulses, so the player block never double-applies damage or heal.

---
 rtl/battle_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_battle_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/battle_sequencer.sv
// battle_sequencer: battle-screen turn sequencer covering the menu, action
// select, attack resolution and the tick-timed dodge phase.
module battle_sequencer #(
  parameter int HP_W        = 8,
  parameter int N_MON       = 3,
  parameter int MON_HP_MAX  = 100,
  parameter int HEAL_AMT    = 10,
  parameter int DODGE_TICKS = 300
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [3:0]            key,
  input  logic                  is_death,
  input  logic                  atk_pass,
  input  logic [HP_W-1:0]       dmg_mon,
  input  logic                  hit_valid,
  input  logic [HP_W-1:0]       hit_dmg,
  output logic [7:0]            state,
  output logic [15:0]           player_instr,
  output logic                  instr_valid,
  output logic                  is_move,
  output logic                  start_dmg,
  output logic [1:0]            target,
  output logic [N_MON*HP_W-1:0] mon_hp,
  output logic                  all_dead
);
  typedef enum logic [3:0] {
    P_MENU   = 4'h1,
    P_DODGE  = 4'h9,
    P_ATTACK = 4'hA,
    P_ACTION = 4'hB
  } page_t;

  localparam logic [3:0] K_W = 4'd1;
  localparam logic [3:0] K_D = 4'd2;
  localparam logic [3:0] K_S = 4'd3;
  localparam logic [3:0] K_A = 4'd4;
  localparam logic [3:0] K_J = 4'd5;
  localparam logic [3:0] K_K = 4'd6;
  localparam logic [3:0] K_L = 4'd7;
  localparam logic [3:0] K_SPC = 4'd8;

  localparam logic [3:0] OP_HPY = 4'h1;
  localparam logic [3:0] OP_DPY = 4'h2;
  localparam logic [3:0] OP_MOV = 4'h5;

  localparam logic [15:0]     DT   = 16'(DODGE_TICKS);
  localparam logic [HP_W-1:0] HPM  = HP_W'(MON_HP_MAX);
  localparam logic [7:0]      HEAL = 8'(HEAL_AMT);

  page_t                  page_q, page_d;
  logic [3:0]             sub_q, sub_d;
  logic [15:0]            instr_q, instr_d;
  logic                   iv_q, iv_d;
  logic                   mv_q, mv_d;
  logic                   sd_q, sd_d;
  logic [1:0]             tgt_q, tgt_d;
  logic [N_MON*HP_W-1:0]  hp_q, hp_d;
  logic [3:0]             key_q;
  logic [15:0]            cnt_q, cnt_d;

  logic                   k_edge;
  logic [1:0]             nxt, prv, low;
  logic                   mv_ok;
  logic [7:0]             mv_arg;
  logic                   any_left;
  logic [HP_W-1:0]        cur_hp;

  assign k_edge = (key != 4'd0) && (key != key_q);

  // Nearest living neighbours of the current target, plus the first survivor.
  always_comb begin
    nxt = tgt_q;
    prv = tgt_q;
    low = '0;
    for (int k = N_MON - 1; k >= 1; k--) begin
      if (hp_q[((int'(tgt_q) + k) % N_MON)*HP_W +: HP_W] != '0)
        nxt = 2'((int'(tgt_q) + k) % N_MON);
      if (hp_q[((int'(tgt_q) + N_MON - k) % N_MON)*HP_W +: HP_W] != '0)
        prv = 2'((int'(tgt_q) + N_MON - k) % N_MON);
    end
    for (int i = N_MON - 1; i >= 0; i--)
      if (hp_q[i*HP_W +: HP_W] != '0) low = 2'(i);
  end

  always_comb begin
    mv_ok  = 1'b1;
    mv_arg = 8'd0;
    unique case (1'b1)
      key == K_W: mv_arg = 8'd0;
      key == K_A: mv_arg = 8'd1;
      key == K_S: mv_arg = 8'd2;
      key == K_D: mv_arg = 8'd3;
      default:    mv_ok  = 1'b0;
    endcase
  end

  always_comb begin
    page_d   = page_q;
    sub_d    = sub_q;
    instr_d  = instr_q;
    iv_d     = 1'b0;
    mv_d     = 1'b0;
    sd_d     = 1'b0;
    tgt_d    = tgt_q;
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    any_left = 1'b0;
    cur_hp   = hp_q[int'(tgt_q)*HP_W +: HP_W];
    unique case (page_q)
      P_MENU: begin
        if (k_edge && key == K_SPC) begin
          page_d = P_ACTION;
          sub_d  = 4'd0;
          tgt_d  = 2'd0;
          hp_d   = {N_MON{HPM}};
        end
      end
      P_ACTION: begin
        unique case (1'b1)
          k_edge && key == K_A: begin
            tgt_d = prv;
            sub_d = {2'b00, prv};
          end
          k_edge && key == K_D: begin
            tgt_d = nxt;
            sub_d = {2'b00, nxt};
          end
          k_edge && key == K_J: begin
            page_d = P_ATTACK;
            sub_d  = 4'd0;
            sd_d   = 1'b1;
          end
          k_edge && key == K_K: begin
            page_d  = P_DODGE;
            sub_d   = 4'd0;
            cnt_d   = DT;
            instr_d = {OP_HPY, HEAL, 4'h0};
            iv_d    = 1'b1;
          end
          k_edge && key == K_L: begin
            page_d = P_MENU;
            sub_d  = 4'd0;
          end
          default: ;
        endcase
      end
      P_ATTACK: begin
        if (atk_pass) begin
          hp_d[int'(tgt_q)*HP_W +: HP_W] =
            (cur_hp > dmg_mon) ? cur_hp - dmg_mon : '0;
          for (int i = 0; i < N_MON; i++)
            if (hp_d[i*HP_W +: HP_W] != '0) any_left = 1'b1;
          if (any_left) begin
            page_d = P_DODGE;
            sub_d  = 4'd0;
            cnt_d  = DT;
          end else begin
            page_d = P_MENU;
            sub_d  = 4'd1;
          end
        end
      end
      P_DODGE: begin
        if (is_death) begin
          page_d = P_MENU;
          sub_d  = 4'd2;
        end else begin
          if (hit_valid) begin
            instr_d = {OP_DPY, 8'(hit_dmg), 4'h0};
            iv_d    = 1'b1;
          end else if (tick && mv_ok) begin
            instr_d = {OP_MOV, mv_arg, 4'h0};
            iv_d    = 1'b1;
            mv_d    = 1'b1;
          end
          if (tick && cnt_q != '0) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              page_d = P_ACTION;
              sub_d  = {2'b00, low};
              tgt_d  = low;
            end
          end
        end
      end
      default: begin
        page_d = P_MENU;
        sub_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_q  <= P_MENU;
      sub_q   <= '0;
      instr_q <= '0;
      iv_q    <= 1'b0;
      mv_q    <= 1'b0;
      sd_q    <= 1'b0;
      tgt_q   <= '0;
      hp_q    <= {N_MON{HPM}};
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      page_q  <= page_d;
      sub_q   <= sub_d;
      instr_q <= instr_d;
      iv_q    <= iv_d;
      mv_q    <= mv_d;
      sd_q    <= sd_d;
      tgt_q   <= tgt_d;
      hp_q    <= hp_d;
      key_q   <= key;
      cnt_q   <= cnt_d;
    end
  end

  assign state        = {page_q, sub_q};
  assign player_instr = instr_q;
  assign instr_valid  = iv_q;
  assign is_move      = mv_q;
  assign start_dmg    = sd_q;
  assign target       = tgt_q;
  assign mon_hp       = hp_q;
  assign all_dead     = (hp_q == '0);
endmodule

// File: tb/tb_battle_sequencer.sv
// tb_battle_sequencer: directed vectors for the battle turn sequencer,
// dodge phase shortened to three ticks.
module tb_battle_sequencer;
  logic        clk, reset, tick, is_death, atk_pass, hit_valid;
  logic [3:0]  key;
  logic [7:0]  dmg_mon, hit_dmg;
  logic [7:0]  state;
  logic [15:0] player_instr;
  logic        instr_valid, is_move, start_dmg, all_dead;
  logic [1:0]  target;
  logic [23:0] mon_hp;
  int n_chk = 0;
  int n_fail = 0;

  battle_sequencer #(
    .HP_W(8), .N_MON(3), .MON_HP_MAX(100),
    .HEAL_AMT(10), .DODGE_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .key(key),
    .is_death(is_death), .atk_pass(atk_pass), .dmg_mon(dmg_mon),
    .hit_valid(hit_valid), .hit_dmg(hit_dmg), .state(state),
    .player_instr(player_instr), .instr_valid(instr_valid),
    .is_move(is_move), .start_dmg(start_dmg), .target(target),
    .mon_hp(mon_hp), .all_dead(all_dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key = 4'd0;
    cyc();
    key = k;
    cyc();
    key = 4'd0;
  endtask

  task automatic dodge_out();
    key  = 4'd0;
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
  endtask

  task automatic attack(input logic [7:0] d);
    dmg_mon  = d;
    atk_pass = 1'b1;
    cyc();
    atk_pass = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; key = 4'd0; is_death = 1'b0;
    atk_pass = 1'b0; hit_valid = 1'b0; dmg_mon = 8'd0; hit_dmg = 8'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_state", 32'(state), 32'h10);
    check("rst_instr", 32'(player_instr), 32'h0);
    check("rst_iv", 32'(instr_valid), 32'h0);
    check("rst_mv", 32'(is_move), 32'h0);
    check("rst_sd", 32'(start_dmg), 32'h0);
    check("rst_tgt", 32'(target), 32'h0);
    check("rst_hp", 32'(mon_hp), 32'h646464);
    check("rst_dead", 32'(all_dead), 32'h0);

    key = 4'd8;
    cyc();
    check("spc_state", 32'(state), 32'hB0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("spc_hold", 32'(state), 32'hB0);
    end
    check("spc_hp", 32'(mon_hp), 32'h646464);
    key = 4'd0;

    press(4'd2); check("d1", 32'(state), 32'hB1);
    press(4'd2); check("d2", 32'(target), 32'h2);
    press(4'd2); check("d3", 32'(state), 32'hB0);
    press(4'd5);
    check("j_state", 32'(state), 32'hA0);
    check("j_sd", 32'(start_dmg), 32'h1);
    cyc();
    check("j_sd_off", 32'(start_dmg), 32'h0);
    press(4'd7);
    check("atk_nokey", 32'(state), 32'hA0);
    attack(8'd130);
    check("atk_hp", 32'(mon_hp), 32'h646400);
    check("atk_state", 32'(state), 32'h90);

    key = 4'd1;
    for (int r = 0; r < 3; r++) begin
      repeat (3) cyc();
      check("mov_idle", 32'(instr_valid), 32'h0);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      check("mov_instr", 32'(player_instr), 32'h5000);
      check("mov_iv", 32'(instr_valid), 32'h1);
      check("mov_mv", 32'(is_move), 32'h1);
      check("mov_state", 32'(state), (r == 2) ? 32'hB1 : 32'h90);
    end
    check("skip_dead", 32'(target), 32'h1);
    key = 4'd0;

    hit_valid = 1'b1; hit_dmg = 8'd7; atk_pass = 1'b1; dmg_mon = 8'd50;
    cyc();
    hit_valid = 1'b0; atk_pass = 1'b0;
    check("ign_hit", 32'(instr_valid), 32'h0);
    check("ign_atk", 32'(mon_hp), 32'h646400);

    press(4'd6);
    check("k_state", 32'(state), 32'h90);
    check("k_instr", 32'(player_instr), 32'h10A0);
    check("k_iv", 32'(instr_valid), 32'h1);
    cyc();
    check("k_iv_off", 32'(instr_valid), 32'h0);
    check("k_hold", 32'(player_instr), 32'h10A0);
    key = 4'd1; hit_valid = 1'b1; hit_dmg = 8'd7; tick = 1'b1;
    cyc();
    check("hit_instr", 32'(player_instr), 32'h2070);
    check("hit_iv", 32'(instr_valid), 32'h1);
    check("hit_mv", 32'(is_move), 32'h0);
    hit_valid = 1'b0; key = 4'd2;
    cyc();
    check("movd_instr", 32'(player_instr), 32'h5030);
    check("movd_mv", 32'(is_move), 32'h1);
    hit_valid = 1'b1; hit_dmg = 8'd9;
    cyc();
    hit_valid = 1'b0; tick = 1'b0; key = 4'd0;
    check("hitx_instr", 32'(player_instr), 32'h2090);
    check("hitx_mv", 32'(is_move), 32'h0);
    check("hitx_state", 32'(state), 32'hB1);

    press(4'd6);
    tick = 1'b1;
    repeat (2) cyc();
    is_death = 1'b1;
    cyc();
    is_death = 1'b0; tick = 1'b0;
    check("death_state", 32'(state), 32'h12);
    check("death_iv", 32'(instr_valid), 32'h0);

    press(4'd8);
    check("rs_hp", 32'(mon_hp), 32'h646464);
    press(4'd5); attack(8'd100);
    check("k0_hp", 32'(mon_hp), 32'h646400);
    dodge_out();
    check("k0_tgt", 32'(state), 32'hB1);
    press(4'd4); check("a_wrap", 32'(target), 32'h2);
    press(4'd2); check("d_wrap", 32'(target), 32'h1);
    press(4'd5); attack(8'd255);
    check("k1_hp", 32'(mon_hp), 32'h640000);
    dodge_out();
    check("k1_tgt", 32'(state), 32'hB2);
    press(4'd2); check("d_alone", 32'(target), 32'h2);
    press(4'd5); attack(8'd60);
    check("k2_hp", 32'(mon_hp), 32'h280000);
    check("k2_dead", 32'(all_dead), 32'h0);
    dodge_out();
    press(4'd5); attack(8'd40);
    check("win_state", 32'(state), 32'h11);
    check("win_dead", 32'(all_dead), 32'h1);
    check("win_hp", 32'(mon_hp), 32'h0);

    press(4'd8);
    press(4'd5); attack(8'd20);
    check("p_hp", 32'(mon_hp), 32'h646450);
    dodge_out();
    check("p_tgt", 32'(state), 32'hB0);
    press(4'd6);
    dodge_out();
    press(4'd5);
    check("p_atk", 32'(state), 32'hA0);
    #1 reset = 1'b1;
    #1;
    check("ar_state", 32'(state), 32'h10);
    check("ar_instr", 32'(player_instr), 32'h0);
    check("ar_sd", 32'(start_dmg), 32'h0);
    check("ar_hp", 32'(mon_hp), 32'h646464);
    check("ar_tgt", 32'(target), 32'h0);
    reset = 1'b0;
    cyc();
    check("ar_menu", 32'(state), 32'h10);
    press(4'd8);
    press(4'd6);
    check("ar_k_instr", 32'(player_instr), 32'h10A0);
    check("ar_k_iv", 32'(instr_valid), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
